// File: rtl/mips_register_file.sv
// Register file for the MIPS datapath: r0 reads zero, two combinational read ports
// with write-first bypass, one clocked write port, and the ALU operand-B source mux.
module mips_register_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_A,
  input  logic [ADDR_W-1:0] rd_addr_B,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              alu_src,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] operand_A,
  output logic [DATA_W-1:0] operand_B,
  output logic [DATA_W-1:0] rd_data_B
);

  logic [DATA_W-1:0] reg_file [NUM_REGS];
  logic              wr_live;
  logic              bypass_a;
  logic              bypass_b;
  logic [DATA_W-1:0] read_a;
  logic [DATA_W-1:0] read_b;

  // Writes to r0 are dropped here so neither storage nor bypass ever sees them.
  assign wr_live = wr_en && (wr_addr != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign reg_file[gi] = '0;
      end else begin : g_flop
        logic [DATA_W-1:0] q_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            q_reg <= '0;
          end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
            q_reg <= wr_data;
          end
        end
        assign reg_file[gi] = q_reg;
      end
    end
  endgenerate

  // Bypass is held off during reset so every read port shows zero while rst_n is low.
  assign bypass_a = rst_n && wr_live && (wr_addr == rd_addr_A);
  assign bypass_b = rst_n && wr_live && (wr_addr == rd_addr_B);

  always_comb begin
    read_a = reg_file[rd_addr_A];
    read_b = reg_file[rd_addr_B];
    if (bypass_a) read_a = wr_data;
    if (bypass_b) read_b = wr_data;
  end

  assign operand_A = read_a;
  assign rd_data_B = read_b;
  assign operand_B = alu_src ? imm : read_b;

endmodule
